// File: rtl/relay_ripple_adder.sv
// Relay-style ripple adder: one sum bit resolves every STAGE_CYCLES clocks, LSB first.
// Result registers and flags update together with the one-cycle done pulse.
module relay_ripple_adder #(
  parameter int WIDTH        = 8,
  parameter int STAGE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             zero,
  output logic             sign
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RIPPLE, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    bit_idx;
  logic [CW-1:0]    stage_cnt;
  logic [WIDTH-1:0] b_lat;
  logic [WIDTH-1:0] c_lat;
  logic [WIDTH-1:0] part;
  logic             run_carry;

  logic             bit_b;
  logic             bit_c;
  logic             bit_s;
  logic             bit_co;
  logic             last_stage;
  logic             last_bit;
  logic [WIDTH-1:0] part_next;

  always_comb begin
    bit_b      = b_lat[bit_idx];
    bit_c      = c_lat[bit_idx];
    bit_s      = bit_b ^ bit_c ^ run_carry;
    bit_co     = (bit_b & bit_c) | (bit_b & run_carry) | (bit_c & run_carry);
    last_stage = (stage_cnt == CW'(STAGE_CYCLES - 1));
    last_bit   = (bit_idx == IW'(WIDTH - 1));
    part_next          = part;
    part_next[bit_idx] = bit_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      zero      <= 1'b1;
      sign      <= 1'b0;
      bit_idx   <= '0;
      stage_cnt <= '0;
      b_lat     <= '0;
      c_lat     <= '0;
      part      <= '0;
      run_carry <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back adds
        IDLE, DONE: begin
          if (start) begin
            b_lat     <= b;
            c_lat     <= c;
            run_carry <= carry_in;
            bit_idx   <= '0;
            stage_cnt <= '0;
            part      <= '0;
            busy      <= 1'b1;
            state     <= RIPPLE;
          end else begin
            state <= IDLE;
          end
        end
        RIPPLE: begin
          if (last_stage) begin
            stage_cnt <= '0;
            part      <= part_next;
            run_carry <= bit_co;
            if (last_bit) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              sum   <= part_next;
              carry <= bit_co;
              zero  <= (part_next == '0);
              sign  <= part_next[WIDTH-1];
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            stage_cnt <= stage_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relay_ripple_adder.sv
// Bench for relay_ripple_adder: 8-bit/1-cycle and 4-bit/3-cycle instances checked against
// an arithmetic model every cycle, plus directed literal expectations.
module tb_relay_ripple_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b0;

  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] b8 = '0, c8 = '0;
  logic       busy8, done8, carry8, zero8, sign8;
  logic [7:0] sum8;

  logic       start4 = 1'b0, cin4 = 1'b0;
  logic [3:0] b4 = '0, c4 = '0;
  logic       busy4, done4, carry4, zero4, sign4;
  logic [3:0] sum4;

  relay_ripple_adder #(.WIDTH(8), .STAGE_CYCLES(1)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .b(b8), .c(c8), .carry_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .zero(zero8), .sign(sign8));

  relay_ripple_adder #(.WIDTH(4), .STAGE_CYCLES(3)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .b(b4), .c(c4), .carry_in(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4), .zero(zero4), .sign(sign4));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an add takes W*S clocks, then one done cycle; result is plain modular arithmetic.
  int W [2] = '{8, 4};
  int S [2] = '{1, 3};
  int m_rem [2]  = '{0, 0};
  int m_pend [2] = '{0, 0};
  int m_sum [2]  = '{0, 0};
  bit m_busy [2] = '{0, 0};
  bit m_done [2] = '{0, 0};
  bit m_carry [2] = '{0, 0};

  task automatic step(input int i, input logic st, input int bb, input int cc, input int ci);
    if (m_busy[i]) begin
      m_rem[i]--;
      if (m_rem[i] == 0) begin
        m_busy[i]  = 1'b0;
        m_done[i]  = 1'b1;
        m_sum[i]   = m_pend[i] % (1 << W[i]);
        m_carry[i] = ((m_pend[i] >> W[i]) & 1) != 0;
      end
    end else begin
      m_done[i] = 1'b0;
      if (st === 1'b1) begin
        m_pend[i] = bb + cc + ci;
        m_rem[i]  = W[i] * S[i];
        m_busy[i] = 1'b1;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_rem[i] = 0; m_pend[i] = 0; m_sum[i] = 0;
        m_busy[i] = 0; m_done[i] = 0; m_carry[i] = 0;
      end
    end else begin
      step(0, start8, int'(b8), int'(c8), int'(cin8));
      step(1, start4, int'(b4), int'(c4), int'(cin4));
    end
  end

  task automatic compare(input int i, input string p, input logic bz, input logic dn,
                         input logic [7:0] s, input logic cy, input logic z, input logic sg);
    check({p, "_busy"},  bz, m_busy[i]);
    check({p, "_done"},  dn, m_done[i]);
    check({p, "_sum"},   s, m_sum[i]);
    check({p, "_carry"}, cy, m_carry[i]);
    check({p, "_zero"},  z, m_sum[i] == 0);
    check({p, "_sign"},  sg, ((m_sum[i] >> (W[i] - 1)) & 1) != 0);
  endtask

  always @(negedge clk) begin
    compare(0, "w8", busy8, done8, sum8, carry8, zero8, sign8);
    compare(1, "w4", busy4, done4, {4'b0, sum4}, carry4, zero4, sign4);
  end

  task automatic run8(input logic [7:0] bb, input logic [7:0] cc, input logic ci,
                      input logic [7:0] es, input logic ec, input bit disturb);
    int n;
    @(negedge clk);
    b8 = bb; c8 = cc; cin8 = ci; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (disturb && n <= 4) begin
        b8 = 8'($urandom); c8 = 8'($urandom); cin8 = 1'($urandom);
        start8 = n[0];
      end else begin
        start8 = 1'b0;
      end
    end
    check("w8_latency", n, 8);
    check("w8_lit_sum", sum8, es);
    check("w8_lit_carry", carry8, ec);
    check("w8_lit_zero", zero8, es == 8'h00);
    check("w8_lit_sign", sign8, es[7]);
  endtask

  task automatic run4(input logic [3:0] bb, input logic [3:0] cc, input logic ci,
                      input logic [3:0] es, input logic ec);
    int n;
    @(negedge clk);
    b4 = bb; c4 = cc; cin4 = ci; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (done4 !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("w4_latency", n, 12);
    check("w4_lit_sum", sum4, es);
    check("w4_lit_carry", carry4, ec);
  endtask

  initial begin
    int n;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_sum", sum8, 0);
    check("rst_zero", zero8, 1);
    check("rst_zero4", zero4, 1);
    reset = 1'b0;

    run8(8'h00, 8'h01, 1'b0, 8'h01, 1'b0, 0);
    run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
    run8(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 0);
    run4(4'hF, 4'hF, 1'b1, 4'hF, 1'b1);
    run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1);

    // start held high: done every 9 clocks
    @(negedge clk);
    b8 = 8'h12; c8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check("held_first", n, 9);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (done8 !== 1'b1 && n < 40);
      check("held_period", n, 9);
    end
    start8 = 1'b0;
    repeat (3) @(negedge clk);

    // reset during cycle 4 of a ripple
    b8 = 8'h55; c8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy8, 0);
    check("arst_done", done8, 0);
    check("arst_sum", sum8, 0);
    check("arst_zero", zero8, 1);
    check("arst_carry", carry8, 0);
    @(negedge clk);
    reset = 1'b0;
    run8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0);

    repeat (400) begin
      @(negedge clk);
      b8 = 8'($urandom); c8 = 8'($urandom); cin8 = 1'($urandom);
      start8 = ($urandom_range(0, 3) == 0);
      b4 = 4'($urandom); c4 = 4'($urandom); cin4 = 1'($urandom);
      start4 = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    start8 = 1'b0; start4 = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
